stat_mem_ctrl: RTL and testbench

Sequencing and arbitration controller for the per-flow statistics RAM. It accepts packet-size updates from the receive side and flow-stat reads from the host side, and shares one single-port RAM between them. Each update is a read-modify-write that adds the packet size to the flow's 32-bit counter, with saturation. The block sits between the rx parser / host register interface and the statistics memory, and owns RAM initialisation after reset.

---
 rtl/stat_mem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_stat_mem_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stat_mem_ctrl.sv
// Per-flow statistics RAM controller: zeroes the RAM after reset, then serialises
// saturating packet-size updates and host (clear-on-)reads over one single-port RAM.
module stat_mem_ctrl #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 32,
  parameter int P_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rx_valid_i,
  output logic               rx_ready_o,
  input  logic [A_WIDTH-1:0] rx_flow_num_i,
  input  logic [P_WIDTH-1:0] pkt_size_i,
  input  logic               rd_valid_i,
  output logic               rd_ready_o,
  input  logic [A_WIDTH-1:0] rd_flow_num_i,
  input  logic               rd_clear_i,
  output logic [D_WIDTH-1:0] rd_data_o,
  output logic               rd_data_valid_o,
  output logic               sat_o,
  output logic               init_done_o,
  output logic               mem_en_o,
  output logic               mem_we_o,
  output logic [A_WIDTH-1:0] mem_addr_o,
  output logic [D_WIDTH-1:0] mem_wdata_o,
  input  logic [D_WIDTH-1:0] mem_rdata_i
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  localparam logic [A_WIDTH-1:0] SWEEP_LAST = {A_WIDTH{1'b1}};
  localparam logic               GRANT_RX   = 1'b0;
  localparam logic               GRANT_HOST = 1'b1;

  // Saturating add; bit D_WIDTH flags that the true sum overflowed.
  function automatic logic [D_WIDTH:0] sat_add(input logic [D_WIDTH-1:0] a,
                                               input logic [P_WIDTH-1:0] b);
    logic [D_WIDTH:0] sum;
    sum = (D_WIDTH+1)'(a) + (D_WIDTH+1)'(b);
    if (sum[D_WIDTH]) begin
      sat_add = {1'b1, {D_WIDTH{1'b1}}};
    end else begin
      sat_add = sum;
    end
  endfunction

  logic [1:0]         state_r;
  logic [A_WIDTH-1:0] sweep_r;
  logic               last_grant_r;
  logic               op_rd_r;
  logic [A_WIDTH-1:0] flow_r;
  logic [P_WIDTH-1:0] size_r;
  logic               clear_r;
  logic [D_WIDTH-1:0] rd_data_r;
  logic               rd_data_valid_r;
  logic               sat_r;
  logic               init_done_r;

  logic               grant_rx_s;
  logic               grant_rd_s;
  logic               mem_en_s;
  logic               mem_we_s;
  logic [A_WIDTH-1:0] mem_addr_s;
  logic [D_WIDTH-1:0] mem_wdata_s;
  logic [D_WIDTH:0]   sum_s;

  assign sum_s = sat_add(mem_rdata_i, size_r);

  // Arbitration and RAM command decode; everything is masked while reset is held
  // so an in-flight write cannot land on the reset edge.
  always_comb begin
    grant_rx_s  = 1'b0;
    grant_rd_s  = 1'b0;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    if (!rst_i) begin
      mem_en_s = 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          mem_en_s   = 1'b1;
          mem_we_s   = 1'b1;
          mem_addr_s = sweep_r;
        end
        ST_IDLE: begin
          grant_rx_s = rx_valid_i && (!rd_valid_i || (last_grant_r == GRANT_HOST));
          grant_rd_s = rd_valid_i && (!rx_valid_i || (last_grant_r == GRANT_RX));
          if (grant_rx_s) begin
            mem_en_s   = 1'b1;
            mem_addr_s = rx_flow_num_i;
          end else if (grant_rd_s) begin
            mem_en_s   = 1'b1;
            mem_addr_s = rd_flow_num_i;
          end else begin
            mem_en_s = 1'b0;
          end
        end
        ST_UPDATE: begin
          mem_addr_s = flow_r;
          if (!op_rd_r) begin
            mem_en_s    = 1'b1;
            mem_we_s    = 1'b1;
            mem_wdata_s = sum_s[D_WIDTH-1:0];
          end else if (clear_r) begin
            mem_en_s = 1'b1;
            mem_we_s = 1'b1;
          end else begin
            mem_en_s = 1'b0;
          end
        end
        default: begin
          mem_en_s = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, request capture and registered result/pulse outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r         <= ST_INIT;
      sweep_r         <= '0;
      last_grant_r    <= GRANT_HOST;
      op_rd_r         <= 1'b0;
      flow_r          <= '0;
      size_r          <= '0;
      clear_r         <= 1'b0;
      rd_data_r       <= '0;
      rd_data_valid_r <= 1'b0;
      sat_r           <= 1'b0;
      init_done_r     <= 1'b0;
    end else begin
      rd_data_valid_r <= 1'b0;
      sat_r           <= 1'b0;
      case (state_r)
        ST_INIT: begin
          if (sweep_r == SWEEP_LAST) begin
            state_r     <= ST_IDLE;
            init_done_r <= 1'b1;
          end else begin
            sweep_r <= sweep_r + A_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          if (grant_rx_s) begin
            op_rd_r      <= 1'b0;
            flow_r       <= rx_flow_num_i;
            size_r       <= pkt_size_i;
            clear_r      <= 1'b0;
            last_grant_r <= GRANT_RX;
            state_r      <= ST_UPDATE;
          end else if (grant_rd_s) begin
            op_rd_r      <= 1'b1;
            flow_r       <= rd_flow_num_i;
            clear_r      <= rd_clear_i;
            last_grant_r <= GRANT_HOST;
            state_r      <= ST_UPDATE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_UPDATE: begin
          if (!op_rd_r) begin
            sat_r <= sum_s[D_WIDTH];
          end else begin
            rd_data_r       <= mem_rdata_i;
            rd_data_valid_r <= 1'b1;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_INIT;
          sweep_r <= '0;
        end
      endcase
    end
  end

  assign rx_ready_o      = grant_rx_s;
  assign rd_ready_o      = grant_rd_s;
  assign mem_en_o        = mem_en_s;
  assign mem_we_o        = mem_we_s;
  assign mem_addr_o      = mem_addr_s;
  assign mem_wdata_o     = mem_wdata_s;
  assign rd_data_o       = rd_data_r;
  assign rd_data_valid_o = rd_data_valid_r;
  assign sat_o           = sat_r;
  assign init_done_o     = init_done_r;

endmodule

// File: tb/tb_stat_mem_ctrl.sv
// Directed bench for stat_mem_ctrl with a 16-entry behavioural RAM attached.
module tb_stat_mem_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] rx_flow;
  logic [PW-1:0] pkt_size;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_flow;
  logic          rd_clear;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          sat;
  logic          init_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [16];
  int total = 0;
  int bad = 0;
  int bad_wr = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] last_rd = 32'd0;

  always #5 clk = ~clk;

  stat_mem_ctrl #(.A_WIDTH(AW), .D_WIDTH(DW), .P_WIDTH(PW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_flow_num_i(rx_flow), .pkt_size_i(pkt_size),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_flow_num_i(rd_flow), .rd_clear_i(rd_clear),
    .rd_data_o(rd_data), .rd_data_valid_o(rd_data_valid), .sat_o(sat), .init_done_o(init_done),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
    if (mon_en && mem_en && mem_we && mem_addr == 4'd2 && mem_wdata != 32'd0) bad_wr++;
  end

  typedef struct {
    bit            op_rd;
    logic [AW-1:0] flow;
    logic [PW-1:0] size;
    bit            clear;
    logic [DW-1:0] exp_data;
    bit            exp_sat;
  } vec_t;

  vec_t vecs[16];
  logic [1:0] exp_grant [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_pulses", 32'({rd_data_valid, sat}), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'({rx_ready, rd_ready}), 32'd0);
  endtask

  // Caller releases reset just after a falling edge; this checks the full sweep.
  task automatic check_sweep();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("sweep_en_we", 32'({mem_en, mem_we}), 32'd3);
      chk("sweep_addr", 32'(mem_addr), 32'(i));
      chk("sweep_wdata", mem_wdata, 32'd0);
      chk("sweep_done_low", 32'(init_done), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("init_done", 32'(init_done), 32'd1);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
  endtask

  task automatic run_op(input vec_t v);
    bit acc;
    int waited;
    @(negedge clk);
    if (v.op_rd) begin
      rd_valid = 1'b1; rd_flow = v.flow; rd_clear = v.clear;
    end else begin
      rx_valid = 1'b1; rx_flow = v.flow; pkt_size = v.size;
    end
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 20) begin
      #1;
      if (v.op_rd ? rd_ready : rx_ready) acc = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    chk("accept", 32'(acc), 32'd1);
    if (acc) begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0; rd_valid = 1'b0;
      @(negedge clk); #1;
      chk("pulse_early", 32'({rd_data_valid, sat}), 32'd0);
      chk("ready_in_update", 32'({rx_ready, rd_ready}), 32'd0);
      @(negedge clk); #1;
      chk("rd_data_valid", 32'(rd_data_valid), 32'(v.op_rd));
      chk("sat", 32'(sat), 32'(v.exp_sat));
      chk("rd_data", rd_data, v.op_rd ? v.exp_data : last_rd);
      if (v.op_rd) last_rd = v.exp_data;
      @(negedge clk); #1;
      chk("pulse_width", 32'({rd_data_valid, sat}), 32'd0);
    end else begin
      rx_valid = 1'b0; rd_valid = 1'b0;
    end
  endtask

  function automatic vec_t mk(bit r, int f, logic [31:0] s, bit c, logic [31:0] d, bit st);
    vec_t v;
    v.op_rd = r; v.flow = AW'(f); v.size = s; v.clear = c; v.exp_data = d; v.exp_sat = st;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(1'b1, 7, 32'd0,          1'b0, 32'd0,          1'b0);
    vecs[1]  = mk(1'b0, 5, 32'd100,        1'b0, 32'd0,          1'b0);
    vecs[2]  = mk(1'b0, 5, 32'd60,         1'b0, 32'd0,          1'b0);
    vecs[3]  = mk(1'b1, 5, 32'd0,          1'b0, 32'd160,        1'b0);
    vecs[4]  = mk(1'b1, 5, 32'd0,          1'b1, 32'd160,        1'b0);
    vecs[5]  = mk(1'b1, 5, 32'd0,          1'b0, 32'd0,          1'b0);
    vecs[6]  = mk(1'b0, 3, 32'hFFFF_FFF0,  1'b0, 32'd0,          1'b0);
    vecs[7]  = mk(1'b0, 3, 32'h20,         1'b0, 32'd0,          1'b1);
    vecs[8]  = mk(1'b1, 3, 32'd0,          1'b0, 32'hFFFF_FFFF,  1'b0);
    vecs[9]  = mk(1'b0, 3, 32'd1,          1'b0, 32'd0,          1'b1);
    vecs[10] = mk(1'b1, 3, 32'd0,          1'b0, 32'hFFFF_FFFF,  1'b0);
    vecs[11] = mk(1'b0, 4, 32'hFFFF_FFFF,  1'b0, 32'd0,          1'b0);
    vecs[12] = mk(1'b1, 4, 32'd0,          1'b0, 32'hFFFF_FFFF,  1'b0);
    vecs[13] = mk(1'b0, 4, 32'd0,          1'b0, 32'd0,          1'b0);
    vecs[14] = mk(1'b1, 4, 32'd0,          1'b1, 32'hFFFF_FFFF,  1'b0);
    vecs[15] = mk(1'b1, 4, 32'd0,          1'b0, 32'd0,          1'b0);
    exp_grant = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

    for (int i = 0; i < 16; i++) ram[i] = 32'hDEAD_BEEF;
    rst_i = 1'b0; rx_valid = 1'b0; rd_valid = 1'b0;
    rx_flow = '0; rd_flow = '0; pkt_size = '0; rd_clear = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    rst_i = 1'b1;
    check_sweep();

    for (int i = 0; i < 16; i++) run_op(vecs[i]);

    // Both requesters held for 8 cycles: rx wins first, then strict alternation.
    @(negedge clk);
    rx_valid = 1'b1; rx_flow = 4'd9; pkt_size = 32'd1;
    rd_valid = 1'b1; rd_flow = 4'd9; rd_clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_grant", 32'({rx_ready, rd_ready}), 32'(exp_grant[i]));
      if (i == 4) begin
        chk("rr_rd1_valid", 32'(rd_data_valid), 32'd1);
        chk("rr_rd1_data", rd_data, 32'd1);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0; rd_valid = 1'b0;
    #1;
    chk("rr_rd2_valid", 32'(rd_data_valid), 32'd1);
    chk("rr_rd2_data", rd_data, 32'd2);
    last_rd = 32'd2;
    @(negedge clk);
    run_op(mk(1'b1, 9, 32'd0, 1'b0, 32'd2, 1'b0));

    // Reset lands in the UPDATE cycle of an update to flow 2.
    @(negedge clk);
    rx_valid = 1'b1; rx_flow = 4'd2; pkt_size = 32'd77;
    #1;
    chk("mid_accept", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst_i = 1'b0; mon_en = 1'b1;
    #1;
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    #1;
    check_reset_vals();
    rst_i = 1'b1;
    check_sweep();
    chk("no_write_flow2", 32'(bad_wr), 32'd0);
    mon_en = 1'b0;
    last_rd = 32'd0;
    run_op(mk(1'b1, 2, 32'd0, 1'b0, 32'd0, 1'b0));
    run_op(mk(1'b1, 5, 32'd0, 1'b0, 32'd0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
